ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the fetch counter.
REQ-003 The block SHALL have port sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port sys_rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid  output  1  instruction memory request valid.
REQ-006 The block SHALL have port req_ready  input  1  memory accepts the request.
REQ-007 The block SHALL have port req_addr  output  32  fetch address, word aligned.
REQ-008 The block SHALL have port rsp_valid  input  1  memory response valid, one-cycle pulse, no earlier than the cycle after acceptance.
REQ-009 The block SHALL have port rsp_data  input  32  fetched instruction word.
REQ-010 The block SHALL have port rsp_err  input  1  access fault for this response.
REQ-011 The block SHALL have port inst_valid  output  1  instruction available to the decode stage.
REQ-012 The block SHALL have port inst_ready  input  1  decode stage consumes the instruction.
REQ-013 The block SHALL have port inst  output  32  registered instruction word.
REQ-014 The block SHALL have port inst_pc  output  32  address of inst.
REQ-015 The block SHALL have port inst_err  output  1  registered rsp_err of inst.
REQ-016 The block SHALL have port pc_wen  input  1  redirect request from write-back (branch, jump, trap).
REQ-017 The block SHALL have port pc_wdata  input  32  redirect target.
REQ-018 The block SHALL have port fetch_cnt  output  CNT_W  count of instructions handed to decode.

Function
REQ-019 The block SHALL implement states IDLE, REQ, WAIT, OUT.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-021 In REQ the block SHALL assert req_valid with req_addr = pc, and go to WAIT on req_valid && req_ready.
REQ-022 req_addr SHALL stay stable while req_valid is high and req_ready is low, including across a redirect.
REQ-023 In WAIT, on rsp_valid the block SHALL register rsp_data, rsp_err and pc into inst, inst_err and inst_pc, then go to OUT.
REQ-024 In OUT the block SHALL assert inst_valid and hold inst, inst_pc and inst_err stable until inst_ready.
REQ-025 On inst_valid && inst_ready the block SHALL set pc <= pc + 4 (32-bit wrap), increment fetch_cnt (wraps at 2^CNT_W) and go to REQ.
REQ-026 Minimum latency SHALL be: request accepted cycle N, rsp_valid cycle N+1, inst_valid cycle N+2.
REQ-027 pc_wen SHALL load pc <= {pc_wdata[31:2], 2'b00} in any state except IDLE, where it is ignored.
REQ-028 pc_wen in REQ SHALL keep the current request and set flag discard.
REQ-029 pc_wen in WAIT SHALL set flag discard.
REQ-030 A response arriving while discard is set, or in the same cycle as pc_wen, SHALL be dropped, clear discard and go to REQ with the new pc.
REQ-031 pc_wen in OUT SHALL deassert inst_valid the next cycle and go to REQ.
REQ-032 pc_wen coinciding with an OUT handshake SHALL count the instruction, and the redirect target SHALL win over pc + 4.
REQ-033 rsp_valid outside WAIT SHALL be ignored.
REQ-034 inst_err SHALL NOT stop fetching.

Reset
REQ-035 Asserting sys_rst (low) SHALL, asynchronously and in any state including mid-transaction, set state = IDLE, pc = RESET_PC and discard = 0.
REQ-036 Reset SHALL force req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_err = 0 and fetch_cnt = 0.
REQ-037 After reset release the first request SHALL appear on the second rising edge.

Structure
REQ-038 Package npc_pkg SHALL hold the fetch_state_t enum (IDLE, REQ, WAIT, OUT) and the constant NPC_RESET_PC = 32'h8000_0000.
REQ-039 The block SHALL be a single module with no sub-module.

Verification
REQ-040 Reset, then req_ready = 1 and a one-cycle rsp latency SHALL give req_addr 0x80000000, then 0x80000004, with inst_valid at cycle N+2 each time.
REQ-041 req_ready held low 5 cycles SHALL keep req_valid = 1 and req_addr stable; asserting pc_wen = 0x80000100 meanwhile SHALL still drop the old response, and the next request SHALL be 0x80000100.
REQ-042 pc_wen = 0x80000203 in the rsp_valid cycle SHALL give no inst_valid and a next req_addr of 0x80000200.
REQ-043 inst_ready low 4 cycles in OUT SHALL hold inst and inst_pc stable; a simultaneous inst_ready and pc_wen = 0x80000040 SHALL give fetch_cnt +1 and a next req_addr of 0x80000040.
REQ-044 rsp_err = 1 at 0x80000008 SHALL give inst_err = 1 and inst_pc 0x80000008, and the next fetch SHALL be 0x8000000C.
REQ-045 sys_rst low during WAIT SHALL immediately clear req_valid, inst_valid and fetch_cnt, and fetching SHALL restart at 0x80000000.

Source files
------------

// File: rtl/npc_pkg.sv
// ----------------------------------------------------------------------------
// npc_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state (IDLE, REQ, WAIT, OUT)
//   NPC_RESET_PC  : default first fetch address after reset
//   word_align()  : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package npc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ifu_fetch_if
// Bundles the fetch unit's memory, decode and redirect signals.
//   master : the fetch unit side (drives req_*, inst_*)
//   slave  : the environment side (memory, decode, write-back)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once valid rises, it and its payload hold until that transfer
// (a redirect may withdraw inst_valid, never req_valid).
// ----------------------------------------------------------------------------
interface ifu_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        pc_wen;
    logic [31:0] pc_wdata;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, inst_err,
        input  req_ready, rsp_valid, rsp_data, rsp_err, inst_ready,
               pc_wen, pc_wdata
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_err,
        output req_ready, rsp_valid, rsp_data, rsp_err, inst_ready,
               pc_wen, pc_wdata
    );
endinterface

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Single-outstanding instruction fetch unit: requests one word from
// instruction memory, registers the response and hands it to decode, then
// advances the pc by 4. A redirect from write-back replaces the pc at any
// time after the first cycle out of reset; a request already issued is
// completed and its response thrown away.
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-low reset
//   req_valid/ready/addr      instruction memory request
//   rsp_valid/data/err        instruction memory response (one-cycle pulse)
//   inst_valid/ready          handshake to decode
//   inst, inst_pc, inst_err   registered instruction, its address and fault
//   pc_wen, pc_wdata          redirect request and target
//   fetch_cnt                 instructions handed to decode (wrapping)
//   dbg_state                 current FSM state, for observation only
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid and its payload are held until then, except that a
// redirect withdraws inst_valid.
// ----------------------------------------------------------------------------
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [31:0]      req_addr,
    input  logic             rsp_valid,
    input  logic [31:0]      rsp_data,
    input  logic             rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic             inst_err,
    input  logic             pc_wen,
    input  logic [31:0]      pc_wdata,
    output logic [CNT_W-1:0] fetch_cnt,
    output fetch_state_t     dbg_state
);

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_req_addr;   // frozen copy of pc for the live request
    logic             r_discard;    // the outstanding response is stale
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_pc;
    logic             r_inst_err;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_target;
    logic [31:0]      w_redirect_pc;
    logic [31:0]      w_advance_pc;
    logic             w_drop;

    assign w_target      = word_align(pc_wdata);
    // pc after a dropped response: a same-cycle redirect takes priority
    assign w_redirect_pc = pc_wen ? w_target : r_pc;
    // pc after leaving OUT: a redirect wins over sequential advance
    assign w_advance_pc  = pc_wen ? w_target : (r_pc + 32'd4);
    assign w_drop        = r_discard | pc_wen;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_discard  <= 1'b0;
            r_inst     <= 32'd0;
            r_inst_pc  <= 32'd0;
            r_inst_err <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= REQ;
                    r_req_addr <= r_pc;
                end
                REQ: begin
                    // r_req_addr is left alone so the live request stays stable
                    if (pc_wen) begin
                        r_pc      <= w_target;
                        r_discard <= 1'b1;
                    end
                    if (req_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (w_drop) begin
                            r_discard  <= 1'b0;
                            r_pc       <= w_redirect_pc;
                            r_req_addr <= w_redirect_pc;
                            r_state    <= REQ;
                        end else begin
                            r_inst     <= rsp_data;
                            r_inst_err <= rsp_err;
                            r_inst_pc  <= r_pc;
                            r_state    <= OUT;
                        end
                    end else if (pc_wen) begin
                        r_pc      <= w_target;
                        r_discard <= 1'b1;
                    end
                end
                OUT: begin
                    if (pc_wen || inst_ready) begin
                        if (inst_ready) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        r_pc       <= w_advance_pc;
                        r_req_addr <= w_advance_pc;
                        r_state    <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_valid  = (r_state == REQ);
    assign req_addr   = r_req_addr;
    assign inst_valid = (r_state == OUT);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_err   = r_inst_err;
    assign fetch_cnt  = r_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
// Directed cycle table for the fetch unit's documented scenarios, a
// hand-written asynchronous reset sequence, and a randomized run against a
// transaction-level model of the instruction stream.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;
    import npc_pkg::*;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic [31:0]  fetch_cnt;
    fetch_state_t dbg_state;
    int           checks   = 0;
    int           failures = 0;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req_valid  (bus.req_valid),
        .req_ready  (bus.req_ready),
        .req_addr   (bus.req_addr),
        .rsp_valid  (bus.rsp_valid),
        .rsp_data   (bus.rsp_data),
        .rsp_err    (bus.rsp_err),
        .inst_valid (bus.inst_valid),
        .inst_ready (bus.inst_ready),
        .inst       (bus.inst),
        .inst_pc    (bus.inst_pc),
        .inst_err   (bus.inst_err),
        .pc_wen     (bus.pc_wen),
        .pc_wdata   (bus.pc_wdata),
        .fetch_cnt  (fetch_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory contents ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[6:2] == 5'd3);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_data   = 32'd0;
        bus.rsp_err    = 1'b0;
        bus.inst_ready = 1'b0;
        bus.pc_wen     = 1'b0;
        bus.pc_wdata   = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_valid"},  32'(bus.req_valid),  32'd0);
        chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, "_inst"},       bus.inst,            32'd0);
        chk({tag, "_inst_pc"},    bus.inst_pc,         32'd0);
        chk({tag, "_inst_err"},   32'(bus.inst_err),   32'd0);
        chk({tag, "_fetch_cnt"},  fetch_cnt,           32'd0);
        chk({tag, "_state"},      32'(dbg_state),      32'(IDLE));
    endtask

    // Hold reset through a few edges, then release just after an edge.
    task automatic do_reset();
        idle_inputs();
        sys_rst = 1'b0;
        repeat (3) step();
        chk_reset_values("rst");
        sys_rst = 1'b1;
        chk("rst_release_req_valid", 32'(bus.req_valid), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rdata;
        logic        rerr;
        logic        ir;
        logic        wen;
        logic [31:0] wdata;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic        e_ierr;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic rr, input logic rv, input logic [31:0] rdata, input logic rerr,
        input logic ir, input logic wen, input logic [31:0] wdata,
        input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
        input logic [31:0] e_ipc, input logic e_ierr, input logic [31:0] e_cnt);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rdata = rdata; v.rerr = rerr;
        v.ir = ir; v.wen = wen; v.wdata = wdata;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_ipc = e_ipc; v.e_ierr = e_ierr; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic build_table();
        // first fetches, minimum latency
        vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h8000_0000, 0,0,0, 0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 0));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0000),0, 0,0,0, 0,0, 1,32'h8000_0000,0, 0));
        vecs.push_back(mk(0,0,0,0, 1,0,0,                 1,32'h8000_0004, 0,0,0, 1));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 1));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0004),0, 0,0,0, 0,0, 1,32'h8000_0004,0, 1));
        vecs.push_back(mk(0,0,0,0, 1,0,0,                 1,32'h8000_0008, 0,0,0, 2));
        // access fault does not stop fetching; decode stalls 4 cycles
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 2));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0008),1, 0,0,0, 0,0, 1,32'h8000_0008,1, 2));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,0, 0,0,0,             0,0, 1,32'h8000_0008,1, 2));
        vecs.push_back(mk(0,0,0,0, 1,0,0,                 1,32'h8000_000C, 0,0,0, 3));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 3));
        vecs.push_back(mk(0,1,mem_word(32'h8000_000C),0, 0,0,0, 0,0, 1,32'h8000_000C,0, 3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,0, 0,0,0,             0,0, 1,32'h8000_000C,0, 3));
        // consume together with redirect: counted, target wins
        vecs.push_back(mk(0,0,0,0, 1,1,32'h8000_0040,     1,32'h8000_0040, 0,0,0, 4));
        // memory stalls 5 cycles, redirect in the middle keeps the request
        vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h8000_0040, 0,0,0, 4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h8000_0040, 0,0,0, 4));
        vecs.push_back(mk(0,0,0,0, 0,1,32'h8000_0100,     1,32'h8000_0040, 0,0,0, 4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h8000_0040, 0,0,0, 4));
        vecs.push_back(mk(0,0,0,0, 0,0,0,                 1,32'h8000_0040, 0,0,0, 4));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 4));
        vecs.push_back(mk(0,1,JUNK,0, 0,0,0,              1,32'h8000_0100, 0,0,0, 4));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 4));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0100),0, 0,0,0, 0,0, 1,32'h8000_0100,0, 4));
        vecs.push_back(mk(0,0,0,0, 1,0,0,                 1,32'h8000_0104, 0,0,0, 5));
        // redirect in the response cycle drops it; low bits of target cleared
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 5));
        vecs.push_back(mk(0,1,JUNK,0, 0,1,32'h8000_0203,  1,32'h8000_0200, 0,0,0, 5));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 5));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0200),0, 0,0,0, 0,0, 1,32'h8000_0200,0, 5));
        vecs.push_back(mk(0,0,0,0, 1,0,0,                 1,32'h8000_0204, 0,0,0, 6));
        // response pulse outside WAIT is ignored
        vecs.push_back(mk(0,1,JUNK,1, 0,0,0,              1,32'h8000_0204, 0,0,0, 6));
        // redirect in OUT without consume
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 6));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0204),0, 0,0,0, 0,0, 1,32'h8000_0204,0, 6));
        vecs.push_back(mk(0,0,0,0, 0,1,32'h8000_0300,     1,32'h8000_0300, 0,0,0, 6));
        // redirect in WAIT before the response
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 6));
        vecs.push_back(mk(0,0,0,0, 0,1,32'h8000_0401,     0,0, 0,0,0, 6));
        vecs.push_back(mk(0,1,JUNK,0, 0,0,0,              1,32'h8000_0400, 0,0,0, 6));
        vecs.push_back(mk(1,0,0,0, 0,0,0,                 0,0, 0,0,0, 6));
        vecs.push_back(mk(0,1,mem_word(32'h8000_0400),0, 0,0,0, 0,0, 1,32'h8000_0400,0, 6));
        vecs.push_back(mk(0,0,0,0, 1,0,0,                 1,32'h8000_0404, 0,0,0, 7));
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            bus.req_ready  = vecs[i].rr;
            bus.rsp_valid  = vecs[i].rv;
            bus.rsp_data   = vecs[i].rdata;
            bus.rsp_err    = vecs[i].rerr;
            bus.inst_ready = vecs[i].ir;
            bus.pc_wen     = vecs[i].wen;
            bus.pc_wdata   = vecs[i].wdata;
            step();
            idle_inputs();
            chk($sformatf("v%0d_req_valid", i),  32'(bus.req_valid),  32'(vecs[i].e_rv));
            chk($sformatf("v%0d_inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d_fetch_cnt", i),  fetch_cnt,           vecs[i].e_cnt);
            if (vecs[i].e_rv)
                chk($sformatf("v%0d_req_addr", i), bus.req_addr, vecs[i].e_addr);
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d_inst_pc", i),  bus.inst_pc,         vecs[i].e_ipc);
                chk($sformatf("v%0d_inst", i),     bus.inst,            mem_word(vecs[i].e_ipc));
                chk($sformatf("v%0d_inst_err", i), 32'(bus.inst_err),   32'(vecs[i].e_ierr));
            end
        end
    endtask

    // ---------------- asynchronous reset while waiting on memory ----------------
    task automatic reset_in_wait();
        bus.req_ready = 1'b1;
        step();
        idle_inputs();
        chk("arst_pre_state", 32'(dbg_state), 32'(WAIT));
        #2;
        sys_rst = 1'b0;
        #1;
        chk("arst_req_valid",  32'(bus.req_valid),  32'd0);
        chk("arst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_fetch_cnt",  fetch_cnt,           32'd0);
        step();
        sys_rst = 1'b1;
        step();
        chk("arst_restart_valid", 32'(bus.req_valid), 32'd1);
        chk("arst_restart_addr",  bus.req_addr,       32'h8000_0000);
        bus.req_ready = 1'b1;
        step();
        idle_inputs();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_word(32'h8000_0000);
        step();
        idle_inputs();
        chk("arst_inst_valid2", 32'(bus.inst_valid), 32'd1);
        chk("arst_inst_pc",     bus.inst_pc,         32'h8000_0000);
    endtask

    // ---------------- randomized run against stream model ----------------
    // The model knows only the architectural stream: each instruction handed
    // to decode sits at the model pc, which advances by 4 per consumed
    // instruction and jumps to the aligned target on any redirect.
    logic [31:0] exp_q[$];

    task automatic run_random(input int n_cycles);
        logic [31:0] model_pc;
        logic [31:0] model_cnt;
        logic        pending;
        int          lat;
        logic [31:0] pend_addr;
        logic        prev_req_stall;
        logic [31:0] prev_addr;
        logic        prev_inst_stall;
        logic [31:0] prev_inst;
        logic [31:0] prev_ipc;
        int          consumed;
        logic [31:0] exp_pc;

        do_reset();
        step();
        model_pc  = 32'h8000_0000;
        model_cnt = 32'd0;
        pending   = 1'b0;
        lat       = 0;
        pend_addr = 32'd0;
        prev_req_stall  = 1'b0;
        prev_inst_stall = 1'b0;
        prev_addr = 32'd0;
        prev_inst = 32'd0;
        prev_ipc  = 32'd0;
        consumed  = 0;
        exp_q.delete();
        exp_q.push_back(model_pc);

        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            if (prev_req_stall) begin
                chk("rnd_req_hold_valid", 32'(bus.req_valid), 32'd1);
                chk("rnd_req_hold_addr",  bus.req_addr,       prev_addr);
            end
            if (prev_inst_stall) begin
                chk("rnd_inst_hold_valid", 32'(bus.inst_valid), 32'd1);
                chk("rnd_inst_hold_data",  bus.inst,            prev_inst);
                chk("rnd_inst_hold_pc",    bus.inst_pc,         prev_ipc);
            end

            bus.req_ready  = ($urandom_range(0, 2) != 0);
            bus.inst_ready = ($urandom_range(0, 2) != 0);
            bus.pc_wen     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.pc_wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                bus.pc_wdata = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = JUNK;
            bus.rsp_err   = 1'b0;
            if (pending) begin
                if (lat == 1) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = mem_word(pend_addr);
                    bus.rsp_err   = mem_err(pend_addr);
                    pending       = 1'b0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = $urandom;
                bus.rsp_err   = 1'b1;
            end

            if (bus.req_valid && bus.req_ready) begin
                pending   = 1'b1;
                lat       = $urandom_range(1, 3);
                pend_addr = bus.req_addr;
            end
            if (bus.inst_valid && bus.inst_ready) begin
                exp_pc = exp_q.pop_front();
                chk("rnd_inst_pc",   bus.inst_pc,       exp_pc);
                chk("rnd_inst",      bus.inst,          mem_word(exp_pc));
                chk("rnd_inst_err",  32'(bus.inst_err), 32'(mem_err(exp_pc)));
                chk("rnd_fetch_cnt", fetch_cnt,         model_cnt);
                model_pc  = exp_pc + 32'd4;
                model_cnt = model_cnt + 32'd1;
                consumed++;
                exp_q.push_back(model_pc);
            end
            if (bus.pc_wen) begin
                model_pc = bus.pc_wdata & ~32'd3;
                exp_q.delete();
                exp_q.push_back(model_pc);
            end

            prev_req_stall  = bus.req_valid && !bus.req_ready;
            prev_addr       = bus.req_addr;
            prev_inst_stall = bus.inst_valid && !bus.inst_ready && !bus.pc_wen;
            prev_inst       = bus.inst;
            prev_ipc        = bus.inst_pc;
            step();
        end
        idle_inputs();
        chk("rnd_final_cnt", fetch_cnt, model_cnt);
        chk("rnd_progress", 32'(consumed > 200), 32'd1);
    endtask

    // ---------------- main ----------------
    initial begin
        idle_inputs();
        build_table();
        do_reset();
        run_table();
        reset_in_wait();
        run_random(4000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
